// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C write master.
// FSM states, quarter-phase names and bus constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_AACK,
        S_DATA,
        S_DACK,
        S_STOP,
        S_DONE
    } state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [6:0] I2C_LED_ADDR = 7'b0000111;
    localparam logic       RW_WRITE     = 1'b0;

endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: SCL quarter-period divider.
// Emits a tick every CLK_DIV enabled cycles and a 2-bit quarter phase.
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (clr) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (en) begin
            if (tick) begin
                cnt   <= '0;
                phase <= phase + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_write_ctrl.sv
// i2c_write_ctrl: two-requester single-byte I2C write master.
// Round-robin arbitration, SCL generation and ACK-slot checking.
module i2c_write_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV   = 250,
    parameter bit CHECK_ACK = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    state_e     state, state_n;
    logic       last;
    logic [7:0] shreg;
    logic [7:0] data_q;
    logic [2:0] bit_cnt;
    logic       ack_q;
    logic       err_q;
    logic       tick;
    logic       tick_clr;
    logic       tick_en;
    logic [1:0] phase;
    logic       q_end;
    logic       q_smp;
    logic       pick1;
    logic       scl_o;
    logic       sda_low;

    // requester 1 wins when alone, or when both ask and 0 was served last
    assign pick1   = req[1] & (~req[0] | ~last);
    assign tick_en = (state != S_IDLE);
    assign q_end   = tick && (phase == Q3);
    assign q_smp   = tick && (phase == Q2);

    i2c_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick),
        .phase(phase)
    );

    always_comb begin
        state_n  = state;
        tick_clr = 1'b0;
        scl_o    = 1'b1;
        sda_low  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (|req) begin
                    state_n  = S_START;
                    tick_clr = 1'b1;
                end
            end
            S_START: begin
                sda_low = (phase >= Q2);
                scl_o   = (phase != Q3);
                if (q_end) state_n = S_ADDR;
            end
            S_ADDR, S_DATA: begin
                sda_low = ~shreg[7];
                scl_o   = phase[1];
                if (q_end && bit_cnt == 3'd7)
                    state_n = (state == S_ADDR) ? S_AACK : S_DACK;
            end
            S_AACK: begin
                scl_o = phase[1];
                if (q_end)
                    state_n = (CHECK_ACK && ack_q) ? S_STOP : S_DATA;
            end
            S_DACK: begin
                scl_o = phase[1];
                if (q_end) state_n = S_STOP;
            end
            S_STOP: begin
                sda_low = (phase <= Q1);
                scl_o   = (phase != Q0);
                if (q_end) state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            grant   <= '0;
            last    <= 1'b1;
            shreg   <= '0;
            data_q  <= '0;
            bit_cnt <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        grant   <= pick1 ? 2'b10 : 2'b01;
                        shreg   <= {(pick1 ? addr1 : addr0), RW_WRITE};
                        data_q  <= pick1 ? data1 : data0;
                        bit_cnt <= '0;
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (q_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (state == S_ADDR && bit_cnt == 3'd7)
                            shreg <= data_q;
                        else
                            shreg <= {shreg[6:0], 1'b0};
                    end
                end
                S_AACK, S_DACK: begin
                    if (q_smp) begin
                        ack_q <= sda;
                        err_q <= err_q | sda;
                    end
                end
                S_DONE: begin
                    grant   <= '0;
                    last    <= grant[1];
                    bit_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign done    = (state == S_DONE);
    assign ack_err = done & err_q;
    assign scl     = scl_o;
    assign sda     = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_ctrl.sv
// tb_i2c_write_ctrl: table, directed and random checks of the I2C write
// master on a pulled-up open-drain bus with a behavioural ACKing slave.
`timescale 1ns/1ps
module tb_i2c_write_ctrl;
    import i2c_pkg::*;

    localparam int CD      = 4;
    localparam int FULL_Q  = 4 + 18 * 4 + 4;
    localparam int ABORT_Q = 4 + 9 * 4 + 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] req_b = 2'b00;
    logic [6:0] addr0 = '0, addr1 = '0;
    logic [7:0] data0 = '0, data1 = '0;
    logic [1:0] grant_a, grant_b;
    logic       busy_a, done_a, ack_err_a, scl_a;
    logic       busy_b, done_b, ack_err_b, scl_b;
    wire        sda_a;
    wire        sda_b;
    logic       slave_en = 1'b0;
    logic       slave_pull = 1'b0;

    pullup (sda_a);
    pullup (sda_b);
    assign sda_a = slave_pull ? 1'b0 : 1'bz;

    i2c_write_ctrl #(.CLK_DIV(CD), .CHECK_ACK(1'b1)) dut_a (
        .clk(clk), .reset(reset), .req(req),
        .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
        .grant(grant_a), .busy(busy_a), .done(done_a),
        .ack_err(ack_err_a), .scl(scl_a), .sda(sda_a)
    );

    i2c_write_ctrl #(.CLK_DIV(CD), .CHECK_ACK(1'b0)) dut_b (
        .clk(clk), .reset(reset), .req(req_b),
        .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
        .grant(grant_b), .busy(busy_b), .done(done_b),
        .ack_err(ack_err_b), .scl(scl_b), .sda(sda_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // bus monitor and slave: records SDA on each SCL rise, ACKs bits 9 and 18
    logic bits[$];
    int   rises = 0;
    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            rises      <= 0;
            slave_pull <= 1'b0;
            prev_scl   <= 1'b1;
            prev_sda   <= 1'b1;
        end else begin
            if (scl_a && !prev_scl) begin
                bits.push_back(sda_a);
                rises <= rises + 1;
            end
            if (scl_a && prev_scl && prev_sda && !sda_a) begin
                bits.delete();
                rises <= 0;
            end
            if (!scl_a && prev_scl)
                slave_pull <= slave_en && (rises == 8 || rises == 17);
            prev_scl <= scl_a;
            prev_sda <= sda_a;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    int         t_start, d_last, r_lat, r_dur, r_nb;
    logic [1:0] r_g;
    logic       r_err;
    logic [7:0] r_ab, r_db;

    task automatic wait_start();
        int k = 0;
        while (!busy_a && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("busy_rise", 32'(busy_a), 32'(1));
        r_lat   = k;
        t_start = cyc;
    endtask

    task automatic finish_txn();
        int k = 0;
        while (!done_a && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(done_a), 32'(1));
        r_g   = grant_a;
        r_dur = cyc - t_start;
        r_err = ack_err_a;
        r_nb  = bits.size();
        r_ab  = '0;
        r_db  = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < r_nb) r_ab[7-i] = bits[i];
            if (i + 9 < r_nb) r_db[7-i] = bits[i+9];
        end
        check("bus_idle_at_done", 32'({scl_a, sda_a}), 32'(2'b11));
        d_last = cyc;
        req = req & ~r_g;
        @(negedge clk);
        check("done_one_cycle", 32'({done_a, grant_a}), 32'(0));
    endtask

    task automatic check_txn(input logic [1:0] eg, input logic [6:0] ea,
                             input logic [7:0] ed, input bit ack);
        int nb_exp = ack ? 19 : 10;
        check("grant", 32'(r_g), 32'(eg));
        check("duration", 32'(r_dur), 32'(ack ? FULL_Q * CD : ABORT_Q * CD));
        check("ack_err", 32'(r_err), 32'(!ack));
        check("addr_byte", 32'(r_ab), 32'({ea, RW_WRITE}));
        check("bit_count", 32'(r_nb), 32'(nb_exp));
        if (ack) check("data_byte", 32'(r_db), 32'(ed));
    endtask

    typedef struct {
        logic [1:0] req;
        logic [6:0] a0;
        logic [6:0] a1;
        logic [7:0] d0;
        logic [7:0] d1;
        bit         ack;
        logic [1:0] g1;
        logic [1:0] g2;
        int         dur;
        bit         err;
    } tv_t;

    tv_t tv[6];

    initial begin
        int         k;
        int         t0;
        int         m_last;
        int         rq;
        logic [1:0] f, s;
        bit         ack;

        tv[0] = '{2'b01, I2C_LED_ADDR, 7'h00, 8'hA5, 8'h00, 1'b1, 2'b01, 2'b00, 320, 1'b0};
        tv[1] = '{2'b10, 7'h00, 7'h50, 8'h00, 8'h3C, 1'b1, 2'b10, 2'b00, 320, 1'b0};
        tv[2] = '{2'b11, 7'h12, 7'h7F, 8'h81, 8'h00, 1'b1, 2'b01, 2'b10, 320, 1'b0};
        tv[3] = '{2'b01, 7'h2A, 7'h00, 8'hFF, 8'h00, 1'b0, 2'b01, 2'b00, 176, 1'b1};
        tv[4] = '{2'b11, 7'h01, 7'h40, 8'h01, 8'h80, 1'b1, 2'b10, 2'b01, 320, 1'b0};
        tv[5] = '{2'b10, 7'h00, 7'h00, 8'h00, 8'hFE, 1'b0, 2'b10, 2'b00, 176, 1'b1};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_a", 32'({grant_a, busy_a, done_a, ack_err_a, scl_a, sda_a}),
              32'(7'b0000011));
        check("reset_out_b", 32'({grant_b, busy_b, done_b, ack_err_b, scl_b, sda_b}),
              32'(7'b0000011));
        reset = 1'b0;
        @(negedge clk);
        check("idle_out_a", 32'({grant_a, busy_a, scl_a, sda_a}), 32'(5'b00011));

        // both request together: 0 first, then 1, then again 0, 1
        addr0 = 7'h07; data0 = 8'hA5;
        addr1 = 7'h55; data1 = 8'hC3;
        slave_en = 1'b1;
        req = 2'b11;
        @(negedge clk);
        check("grant_latency", 32'({busy_a, grant_a}), 32'(3'b101));
        t_start = cyc;
        k = 0;
        while (sda_a && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("start_sda_fall", 32'(k), 32'(2 * CD));
        check("start_scl_high", 32'(scl_a), 32'(1));
        finish_txn();
        check_txn(2'b01, 7'h07, 8'hA5, 1'b1);
        wait_start();
        check("b2b_gap", 32'((t_start - d_last) >= 1 && (t_start - d_last) <= 2), 32'(1));
        finish_txn();
        check_txn(2'b10, 7'h55, 8'hC3, 1'b1);
        req = 2'b11;
        wait_start();
        check("idle_req_latency", 32'(r_lat), 32'(1));
        finish_txn();
        check_txn(2'b01, 7'h07, 8'hA5, 1'b1);
        wait_start();
        finish_txn();
        check_txn(2'b10, 7'h55, 8'hC3, 1'b1);

        for (int i = 0; i < 6; i++) begin
            addr0 = tv[i].a0; addr1 = tv[i].a1;
            data0 = tv[i].d0; data1 = tv[i].d1;
            slave_en = tv[i].ack;
            req = tv[i].req;
            wait_start();
            finish_txn();
            check("tv_grant", 32'(r_g), 32'(tv[i].g1));
            check("tv_dur", 32'(r_dur), 32'(tv[i].dur));
            check("tv_err", 32'(r_err), 32'(tv[i].err));
            check_txn(tv[i].g1, tv[i].g1[1] ? tv[i].a1 : tv[i].a0,
                      tv[i].g1[1] ? tv[i].d1 : tv[i].d0, tv[i].ack);
            if (tv[i].g2 != 2'b00) begin
                wait_start();
                finish_txn();
                check("tv_grant2", 32'(r_g), 32'(tv[i].g2));
                check_txn(tv[i].g2, tv[i].g2[1] ? tv[i].a1 : tv[i].a0,
                          tv[i].g2[1] ? tv[i].d1 : tv[i].d0, tv[i].ack);
            end
        end

        // inputs change after grant: bus keeps the latched bytes
        addr0 = 7'h07; data0 = 8'hA5; slave_en = 1'b1;
        req = 2'b01;
        wait_start();
        repeat (60) @(negedge clk);
        data0 = 8'hFF; addr0 = 7'h7F;
        finish_txn();
        check_txn(2'b01, 7'h07, 8'hA5, 1'b1);

        // reset in the middle of data bit 3
        addr0 = 7'h07; data0 = 8'hA5;
        req = 2'b01;
        wait_start();
        repeat ((4 + 32 + 4 + 3 * 4) * CD + 6) @(negedge clk);
        check("pre_reset_bus", 32'({scl_a, sda_a}), 32'(2'b00));
        reset = 1'b1;
        req = 2'b00;
        #1;
        check("rst_mid_bus", 32'({scl_a, sda_a}), 32'(2'b11));
        check("rst_mid_ctrl", 32'({busy_a, grant_a, done_a, ack_err_a}), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req = 2'b01;
        wait_start();
        finish_txn();
        check_txn(2'b01, 7'h07, 8'hA5, 1'b1);

        // no slave, ACK not enforced: full length, error flagged
        slave_en = 1'b0;
        req_b = 2'b01;
        k = 0;
        while (!busy_b && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("b_busy", 32'(busy_b), 32'(1));
        t0 = cyc;
        k = 0;
        while (!done_b && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("b_done", 32'(done_b), 32'(1));
        check("b_duration", 32'(cyc - t0), 32'(FULL_Q * CD));
        check("b_ack_err", 32'(ack_err_b), 32'(1));
        check("b_grant", 32'(grant_b), 32'(2'b01));
        req_b = 2'b00;
        @(negedge clk);

        // random traffic against a round-robin order model
        m_last = 0;
        for (int r = 0; r < 8; r++) begin
            addr0 = 7'($urandom); addr1 = 7'($urandom);
            data0 = 8'($urandom); data1 = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            slave_en = ack;
            rq = $urandom_range(1, 3);
            if (rq == 3) begin
                f = (m_last == 1) ? 2'b01 : 2'b10;
                s = 2'b11 ^ f;
                m_last = s[1] ? 1 : 0;
            end else begin
                f = 2'(rq);
                s = 2'b00;
                m_last = f[1] ? 1 : 0;
            end
            req = 2'(rq);
            wait_start();
            finish_txn();
            check_txn(f, f[1] ? addr1 : addr0, f[1] ? data1 : data0, ack);
            if (s != 2'b00) begin
                wait_start();
                finish_txn();
                check_txn(s, s[1] ? addr1 : addr0, s[1] ? data1 : data0, ack);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
